// File: rtl/dmem_wait_be.sv
// Data memory with byte enables, programmable wait states and a valid/ready request port.
// One request in flight; misaligned or out-of-range accesses answer with rsp_err and no side effect.
module dmem_wait_be #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFS   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               load;
  logic               access;
  req_t               req_in;
  req_t               lat_q;
  req_t               acc;
  logic [IDX_W-1:0]   acc_idx;
  logic               misaligned;
  logic               out_of_range;
  logic               acc_err;
  logic               mem_wr;

  logic [DATA_W-1:0]  mem [DEPTH];

  assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the access happens on the accept edge, so it uses the live request.
  assign acc     = (state == S_IDLE) ? req_in : lat_q;
  assign acc_idx = acc.addr[OFS +: IDX_W];

  assign misaligned = |acc.addr[OFS-1:0];

  if (ADDR_W > OFS + IDX_W) begin : g_hi_bits
    assign out_of_range = |acc.addr[ADDR_W-1:OFS+IDX_W];
  end else begin : g_no_hi_bits
    assign out_of_range = 1'b0;
  end

  assign acc_err = misaligned | out_of_range;
  assign mem_wr  = access & acc.we & ~acc_err & ~rst;

  // State and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state; WAIT lasts LATENCY+1 cycles (counter runs LATENCY down to 0)
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    access     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          load = 1'b1;
          if (LATENCY == 0) begin
            state_next = S_RESP;
            access     = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_W'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_next = S_RESP;
          access     = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Request capture at the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q <= '0;
    end else if (load) begin
      lat_q <= req_in;
    end
  end

  // Registered handshake and response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (state_next == S_IDLE);
      rsp_valid <= access;
      rsp_err   <= access & acc_err;
      rsp_rdata <= (access && !acc.we && !acc_err) ? mem[acc_idx] : '0;
    end
  end

  // Storage is intentionally left uninitialised by reset
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (acc.be[i]) begin
          mem[acc_idx][i*8 +: 8] <= acc.wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_be.sv
// Directed bench for dmem_wait_be: three instances cover LATENCY=2, LATENCY=0 and a 64-bit/16-word/LATENCY=5 build.
module tb_dmem_wait_be;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: 32-bit, 256 words, LATENCY=2
  logic        a_valid, a_ready, a_we, a_rsp_valid, a_rsp_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;

  dmem_wait_be #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err));

  // Instance B: 32-bit, 256 words, LATENCY=0
  logic        b_valid, b_ready, b_we, b_rsp_valid, b_rsp_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  dmem_wait_be #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err));

  // Instance C: 64-bit, 16 words, LATENCY=5
  logic        c_valid, c_ready, c_we, c_rsp_valid, c_rsp_err;
  logic [31:0] c_addr;
  logic [63:0] c_wdata, c_rdata;
  logic [7:0]  c_be;

  dmem_wait_be #(.DATA_W(64), .DEPTH(16), .ADDR_W(32), .LATENCY(5)) u_c (
    .clk(clk), .rst(rst), .req_valid(c_valid), .req_ready(c_ready), .req_we(c_we),
    .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata), .rsp_err(c_rsp_err));

  // One request on A; lat counts falling edges after the accept edge until rsp_valid (-1 on timeout)
  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat, output logic single);
    int n = 0;
    @(negedge clk);
    a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; a_valid = 1'b1;
    while (!a_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_we = ~we; a_addr = 32'hFFFF_FFFC; a_wdata = ~wdata; a_be = ~be;
    lat = -1; rdata = 'x; err = 1'bx; single = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        lat = i; rdata = a_rdata; err = a_rsp_err;
        break;
      end
    end
    @(negedge clk);
    single = !a_rsp_valid;
  endtask

  task automatic txn_c(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [7:0] be, output logic [63:0] rdata, output logic err,
                       output int lat, output logic single);
    int n = 0;
    @(negedge clk);
    c_we = we; c_addr = addr; c_wdata = wdata; c_be = be; c_valid = 1'b1;
    while (!c_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    c_valid = 1'b0; c_we = ~we; c_addr = 32'hFFFF_FFF8; c_wdata = ~wdata; c_be = ~be;
    lat = -1; rdata = 'x; err = 1'bx; single = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (c_rsp_valid) begin
        lat = i; rdata = c_rdata; err = c_rsp_err;
        break;
      end
    end
    @(negedge clk);
    single = !c_rsp_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    c_valid = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", a_ready); end
    n_cmp++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", a_rsp_valid); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", a_rdata); end
    n_cmp++; if (a_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", a_rsp_err); end
    n_cmp++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL rst_c_ready: got %b want 1", c_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", a_ready); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lt; logic one;
    txn_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lt, one);
    n_cmp++; if (lt !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lt); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL wr_rsp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    n_cmp++; if (one !== 1'b1) begin n_fail++; $display("FAIL wr_one_cycle: got %b want 1", one); end
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_fail++; $display("FAIL rd_0x10: got %h err=%b want deadbeef err=0", rd, er); end
    n_cmp++; if (lt !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lt); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd; logic er; int lt; logic one;
    txn_a(1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er, lt, one);
    txn_a(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er, lt, one);
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL be_0101: got %h want 11bb33dd", rd); end
    txn_a(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, rd, er, lt, one);
    n_cmp++; if (er !== 1'b0 || lt !== 3) begin n_fail++; $display("FAIL be_zero_rsp: got err=%b lat=%0d want err=0 lat=3", er, lt); end
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL be_zero_noop: got %h want 11bb33dd", rd); end
    txn_a(1'b1, 32'h20, 32'h9988_7766, 4'b1000, rd, er, lt, one);
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (rd !== 32'h99BB_33DD) begin n_fail++; $display("FAIL be_1000: got %h want 99bb33dd", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lt; logic one;
    txn_a(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, er, lt, one);
    txn_a(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_rd: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    n_cmp++; if (lt !== 3 || one !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got lat=%0d one=%b want lat=3 one=1", lt, one); end
    txn_a(1'b1, 32'h400, 32'h1234_5678, 4'hF, rd, er, lt, one);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", er); end
    txn_a(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin n_fail++; $display("FAIL word0_kept: got %h err=%b want cafef00d err=0", rd, er); end
    txn_a(1'b1, 32'h11, 32'h0, 4'hF, rd, er, lt, one);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_wr_err: got %b want 1", er); end
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL misaligned_no_write: got %h want deadbeef", rd); end
    txn_a(1'b1, 32'h3FC, 32'h7654_3210, 4'hF, rd, er, lt, one);
    txn_a(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (rd !== 32'h7654_3210 || er !== 1'b0) begin n_fail++; $display("FAIL last_word: got %h err=%b want 76543210 err=0", rd, er); end
    txn_a(1'b0, 32'h400, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
  endtask

  // LATENCY=0 with req_valid held: accepts alternate with one-cycle responses
  task automatic test_back_to_back;
    logic exp_ready, exp_valid;
    @(negedge clk);
    b_we = 1'b1; b_addr = 32'h40; b_wdata = 32'h1234_5678; b_be = 4'hF; b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_ready = (i % 2 == 0);
      exp_valid = (i % 2 == 1);
      n_cmp++; if (b_ready !== exp_ready || b_rsp_valid !== exp_valid) begin
        n_fail++; $display("FAIL b2b_wr_%0d: got ready=%b valid=%b want ready=%b valid=%b", i, b_ready, b_rsp_valid, exp_ready, exp_valid);
      end
      @(negedge clk);
    end
    b_we = 1'b0; b_be = 4'h0;
    for (int i = 0; i < 6; i++) begin
      exp_ready = (i % 2 == 0);
      exp_valid = (i % 2 == 1);
      n_cmp++; if (b_ready !== exp_ready || b_rsp_valid !== exp_valid) begin
        n_fail++; $display("FAIL b2b_rd_%0d: got ready=%b valid=%b want ready=%b valid=%b", i, b_ready, b_rsp_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        n_cmp++; if (b_rdata !== 32'h1234_5678 || b_rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL b2b_rdata_%0d: got %h err=%b want 12345678 err=0", i, b_rdata, b_rsp_err);
        end
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lt; logic one;
    logic seen;
    txn_a(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lt, one);
    @(negedge clk);
    a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'h5A5A_5A5A; a_be = 4'hF; a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got ready=%b want 0", a_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_now: got ready=%b valid=%b want ready=1 valid=0", a_ready, a_rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got %b want 0", seen); end
    txn_a(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lt, one);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL mid_no_commit: got %h err=%b want 0 err=0", rd, er); end
  endtask

  task automatic test_param_sweep;
    logic [63:0] rd; logic er; int lt; logic one;
    txn_c(1'b1, 32'h78, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lt, one);
    n_cmp++; if (lt !== 6 || er !== 1'b0) begin n_fail++; $display("FAIL c_wr: got lat=%0d err=%b want lat=6 err=0", lt, er); end
    txn_c(1'b0, 32'h78, 64'h0, 8'h00, rd, er, lt, one);
    n_cmp++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL c_rd: got %h want 0123456789abcdef", rd); end
    n_cmp++; if (lt !== 6 || one !== 1'b1) begin n_fail++; $display("FAIL c_rd_timing: got lat=%0d one=%b want lat=6 one=1", lt, one); end
    txn_c(1'b0, 32'h80, 64'h0, 8'h00, rd, er, lt, one);
    n_cmp++; if (er !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("FAIL c_oor: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    txn_c(1'b1, 32'h7C, 64'h0, 8'hFF, rd, er, lt, one);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL c_misaligned: got %b want 1", er); end
    txn_c(1'b0, 32'h78, 64'h0, 8'h00, rd, er, lt, one);
    n_cmp++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL c_kept: got %h want 0123456789abcdef", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
